// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch unit: next-PC select codes, opcodes,
// fetch FSM state encoding and the default reset PC.
package riscv_pkg;

  localparam logic [1:0] PC_4  = 2'd0;
  localparam logic [1:0] PC_IM = 2'd1;
  localparam logic [1:0] RS_IM = 2'd2;

  localparam logic [6:0] OP_OPIMM  = 7'h13;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read port: request/acknowledge with address and data.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [31:0]       rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC target selection with misalignment detection.
// The returned target always has bits[1:0] cleared.
module next_pc_calc
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] imm,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [1:0]        pc_src,
  output logic [ADDR_W-1:0] target,
  output logic              misaligned
);

  logic [ADDR_W-1:0] raw;

  // Select the raw target; jalr drops bit0 before the alignment check.
  always_comb begin
    raw = pc + ADDR_W'(4);
    case (pc_src)
      PC_4:    raw = pc + ADDR_W'(4);
      PC_IM:   raw = pc + imm;
      RS_IM: begin
        raw    = rs1 + imm;
        raw[0] = 1'b0;
      end
      default: raw = pc + ADDR_W'(4);
    endcase
    misaligned = |raw[1:0];
    target     = {raw[ADDR_W-1:2], 2'b00};
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack port, holds
// and decodes the instruction until the core advances.
// Optional ack watchdog: IFU_FETCH_TIMEOUT_EN.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int                TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  imem,
  input  logic [1:0]          PCSrc,
  input  logic [31:0]         Imm,
  input  logic [31:0]         RS1,
  input  logic                Advance,
  output logic                InstrValid,
  output logic [31:0]         Instr,
  output logic [6:0]          Opcode,
  output logic [2:0]          Funct3,
  output logic [6:0]          Funct7,
  output logic [ADDR_W-1:0]   PC,
  output logic [ADDR_W-1:0]   PCPlus4,
  output logic                Misaligned,
  output logic                FetchFault
);

  fetch_state_t      state, state_nxt;
  logic              capture, load_pc, timeout;
  logic [ADDR_W-1:0] target;
  logic              tgt_misaligned;

  next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc         (PC),
    .imm        (Imm),
    .rs1        (RS1),
    .pc_src     (PCSrc),
    .target     (target),
    .misaligned (tgt_misaligned)
  );

`ifdef IFU_FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] tmo_cnt;

  assign timeout = (state == REQ || state == WAIT) && !imem.ack && (tmo_cnt == '0);

  // Watchdog down-counter, reloaded whenever the FSM enters REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt    <= TMO_LOAD;
      FetchFault <= 1'b0;
    end else begin
      if (state_nxt == REQ)
        tmo_cnt <= TMO_LOAD;
      else if (state == REQ || state == WAIT)
        tmo_cnt <= tmo_cnt - CW'(1);
      if (timeout)
        FetchFault <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout    = 1'b0;
  assign FetchFault = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    load_pc   = 1'b0;
    case (state)
      IDLE:  state_nxt = REQ;
      REQ: begin
        if (imem.ack) begin
          capture   = 1'b1;
          state_nxt = VALID;
        end else if (timeout) begin
          state_nxt = REQ;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem.ack) begin
          capture   = 1'b1;
          state_nxt = VALID;
        end else if (timeout) begin
          state_nxt = REQ;
        end
      end
      VALID: begin
        if (Advance) begin
          load_pc   = 1'b1;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // PC, held instruction and sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      PC         <= RESET_PC;
      Instr      <= '0;
      Misaligned <= 1'b0;
    end else begin
      if (capture)
        Instr <= imem.rdata;
      if (load_pc) begin
        PC <= target;
        if (tgt_misaligned)
          Misaligned <= 1'b1;
      end
    end
  end

  assign InstrValid = (state == VALID);
  assign imem.req   = (state == REQ) || (state == WAIT);
  assign imem.addr  = PC;
  assign PCPlus4    = PC + ADDR_W'(4);
  assign Opcode     = InstrValid ? Instr[6:0]   : 7'd0;
  assign Funct3     = InstrValid ? Instr[14:12] : 3'd0;
  assign Funct7     = InstrValid ? Instr[31:25] : 7'd0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  PCSrc;
  logic [31:0] Imm, RS1;
  logic        Advance;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [6:0]  Opcode, Funct7;
  logic [2:0]  Funct3;
  logic [31:0] PC, PCPlus4;
  logic        Misaligned, FetchFault;

  int nvec  = 0;
  int nmiss = 0;

  instr_fetch_unit_if #(.ADDR_W(32)) imem ();

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(RST_PC), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem       (imem.master),
    .PCSrc      (PCSrc),
    .Imm        (Imm),
    .RS1        (RS1),
    .Advance    (Advance),
    .InstrValid (InstrValid),
    .Instr      (Instr),
    .Opcode     (Opcode),
    .Funct3     (Funct3),
    .Funct7     (Funct7),
    .PC         (PC),
    .PCPlus4    (PCPlus4),
    .Misaligned (Misaligned),
    .FetchFault (FetchFault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmiss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for the fetch request to appear.
  task automatic wait_req();
    int n = 0;
    while (!imem.req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, imem.req}, 32'd1);
  endtask

  // Answer one fetch after 'delay' no-ack cycles; Advance is asserted during
  // the wait to show it has no effect there.
  task automatic serve(input logic [31:0] word, input int delay);
    logic [31:0] a0;
    wait_req();
    a0 = imem.addr;
    for (int i = 0; i < delay; i++) begin
      Advance = 1'b1;
      PCSrc   = 2'd1;
      Imm     = 32'h100;
      chk("wait_req", {31'd0, imem.req}, 32'd1);
      chk("wait_addr", imem.addr, a0);
      @(negedge clk);
    end
    Advance    = 1'b0;
    imem.ack   = 1'b1;
    imem.rdata = word;
    chk("pre_valid", {31'd0, InstrValid}, 32'd0);
    @(negedge clk);
    imem.ack = 1'b0;
    chk("valid", {31'd0, InstrValid}, 32'd1);
    chk("instr", Instr, word);
    chk("req_low", {31'd0, imem.req}, 32'd0);
  endtask

  task automatic advance(input logic [1:0] src, input logic [31:0] imm_v,
                         input logic [31:0] rs1_v);
    PCSrc   = src;
    Imm     = imm_v;
    RS1     = rs1_v;
    Advance = 1'b1;
    @(negedge clk);
    Advance = 1'b0;
  endtask

  initial begin
    rst = 1'b1; Advance = 1'b0; PCSrc = 2'd0; Imm = 32'd0; RS1 = 32'd0;
    imem.ack = 1'b0; imem.rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", PC, RST_PC);
    chk("rst_valid", {31'd0, InstrValid}, 32'd0);
    chk("rst_req", {31'd0, imem.req}, 32'd0);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_opcode", {25'd0, Opcode}, 32'd0);
    chk("rst_mis", {31'd0, Misaligned}, 32'd0);
    chk("rst_fault", {31'd0, FetchFault}, 32'd0);
    rst = 1'b0;

    // 0-wait fetch of addi x1,x0,5
    serve(32'h0050_0093, 0);
    chk("addi_pc", PC, 32'h0040_0000);
    chk("addi_op", {25'd0, Opcode}, {25'd0, OP_OPIMM});
    chk("addi_f3", {29'd0, Funct3}, 32'd0);
    chk("addi_f7", {25'd0, Funct7}, 32'd0);
    advance(2'd0, 32'd0, 32'd0);
    chk("seq_addr", imem.addr, 32'h0040_0004);
    chk("seq_req", {31'd0, imem.req}, 32'd1);

    // 3-cycle ack delay, sub x2,x1,x2
    serve(32'h4020_8133, 3);
    chk("sub_op", {25'd0, Opcode}, {25'd0, OP_OP});
    chk("sub_f7", {25'd0, Funct7}, 32'h20);
    chk("sub_pc", PC, 32'h0040_0004);
    // stray ack while VALID must not overwrite the held word
    imem.ack = 1'b1; imem.rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    imem.ack = 1'b0;
    chk("stray_ack", Instr, 32'h4020_8133);
    chk("stray_valid", {31'd0, InstrValid}, 32'd1);
    advance(2'd1, 32'h0000_000C, 32'd0);
    chk("fwd_pc", PC, 32'h0040_0010);

    // branch backward
    serve(32'hFE20_8CE3, 0);
    chk("beq_op", {25'd0, Opcode}, {25'd0, OP_BRANCH});
    chk("beq_f7", {25'd0, Funct7}, 32'h7F);
    advance(2'd1, 32'hFFFF_FFF8, 32'd0);
    chk("br_pc", PC, 32'h0040_0008);
    chk("br_mis", {31'd0, Misaligned}, 32'd0);

    // jalr aligned after bit0 clear
    serve(32'h0042_80E7, 0);
    chk("jalr_op", {25'd0, Opcode}, {25'd0, OP_JALR});
    advance(2'd2, 32'd4, 32'h0040_0101);
    chk("jalr_pc", PC, 32'h0040_0104);
    chk("jalr_mis0", {31'd0, Misaligned}, 32'd0);

    // jalr misaligned
    serve(32'h0000_0013, 0);
    chk("pcplus4", PCPlus4, 32'h0040_0108);
    advance(2'd2, 32'd0, 32'h0040_0102);
    chk("mis_pc", PC, 32'h0040_0100);
    chk("mis_set", {31'd0, Misaligned}, 32'd1);

    // reserved select behaves as PC+4; Misaligned stays sticky
    serve(32'h0000_0013, 0);
    advance(2'd3, 32'h0000_0100, 32'h0000_0200);
    chk("rsv_pc", PC, 32'h0040_0104);
    chk("mis_sticky", {31'd0, Misaligned}, 32'd1);

    // wrap-around at top of address space
    serve(32'h0000_0013, 0);
    advance(2'd2, 32'd0, 32'hFFFF_FFFC);
    chk("top_pc", PC, 32'hFFFF_FFFC);
    serve(32'h0000_0013, 0);
    chk("wrap_p4", PCPlus4, 32'd0);
    advance(2'd0, 32'd0, 32'd0);
    chk("wrap_pc", PC, 32'd0);

    // reset during WAIT with a coincident ack
    wait_req();
    @(negedge clk);
    rst = 1'b1; imem.ack = 1'b1; imem.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b0; imem.ack = 1'b0;
    chk("rw_pc", PC, RST_PC);
    chk("rw_valid", {31'd0, InstrValid}, 32'd0);
    chk("rw_instr", Instr, 32'd0);
    chk("rw_mis", {31'd0, Misaligned}, 32'd0);
    chk("rw_req", {31'd0, imem.req}, 32'd0);
    serve(32'h0050_0093, 1);
    chk("rw_refetch_pc", PC, RST_PC);
    advance(2'd0, 32'd0, 32'd0);

`ifdef IFU_FETCH_TIMEOUT_EN
    begin
      logic [31:0] a0;
      wait_req();
      a0 = imem.addr;
      for (int i = 0; i < 16; i++) begin
        chk("tmo_nofault", {31'd0, FetchFault}, 32'd0);
        @(negedge clk);
      end
      chk("tmo_fault", {31'd0, FetchFault}, 32'd1);
      chk("tmo_retry_req", {31'd0, imem.req}, 32'd1);
      chk("tmo_retry_addr", imem.addr, a0);
      serve(32'h0000_0013, 2);
      chk("tmo_pc", PC, a0);
      chk("tmo_sticky", {31'd0, FetchFault}, 32'd1);
    end
`else
    begin
      wait_req();
      repeat (20) @(negedge clk);
      chk("no_fault", {31'd0, FetchFault}, 32'd0);
      chk("still_wait", {31'd0, imem.req}, 32'd1);
      serve(32'h0000_0013, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
